// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 2-FF input synchroniser and a FWFT byte FIFO.
// Bytes are pushed the cycle after a good stop bit and popped on valid && ready.
module uart_rx_fifo #(
   parameter int BAUD_DIV   = 868,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rxd,
   input  logic             clr_err,
   input  logic             rx_ready,
   output logic             rx_valid,
   output logic [7:0]       rx_data,
   output logic             frame_err,
   output logic             overflow,
   output logic [CNT_W-1:0] fifo_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BW    = $clog2(BAUD_DIV);
   localparam logic [BW-1:0] LAST      = BW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BRK
   } state_t;

   state_t state_q, state_d;

   logic             meta_q, rxs_q;
   logic [BW-1:0]    baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             push_q, push_d;
   logic             ferr_q, ferr_d;
   logic             ovf_q, ovf_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];

   logic pop, full, wr_en, ovf_set;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + BW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      push_d  = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!rxs_q) state_d = START;
         end
         START: begin
            if (baud_q == HALF_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = rxs_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (baud_q == LAST) begin
               baud_d         = '0;
               shift_d[bit_q] = rxs_q;
               if (bit_q == 3'd7) state_d = STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP: begin
            if (baud_q == LAST) begin
               baud_d = '0;
               if (rxs_q) begin
                  push_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = BRK;
               end
            end
         end
         BRK: begin
            // hold off until the line recovers so a stuck-low line yields one error
            baud_d = '0;
            if (rxs_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      full     = (cnt_q == FULL);
      pop      = (cnt_q != '0) && rx_ready;
      wr_en    = push_q && (!full || pop);
      ovf_set  = push_q && full && !pop;
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
      mem_d    = mem_q;
      if (wr_en) mem_d[wr_ptr_q] = shift_q;
      ovf_d = ovf_q;
      if (clr_err) ovf_d = 1'b0;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q   <= 1'b1;
         rxs_q    <= 1'b1;
         state_q  <= IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         push_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         meta_q   <= rxd;
         rxs_q    <= meta_q;
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         push_q   <= push_d;
         ferr_q   <= ferr_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign rx_valid  = (cnt_q != '0);
   assign rx_data   = mem_q[rd_ptr_q];
   assign frame_err = ferr_q;
   assign overflow  = ovf_q;
   assign fifo_cnt  = cnt_q;

endmodule
